// File: rtl/census_wta_seq_pkg.sv
// Shared constants and state encoding for the census/Hamming WTA sequencer.
package census_wta_seq_pkg;

    localparam int CODEC_W = 120;
    localparam int COST_W  = 8;

    localparam logic [3:0] CE_OP_LD0L = 4'h8;
    localparam logic [3:0] CE_OP_LD0H = 4'h9;
    localparam logic [3:0] CE_OP_LD1L = 4'hA;
    localparam logic [3:0] CE_OP_LD1H = 4'hB;
    localparam logic [3:0] CE_OP_HAM  = 4'hC;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LD0L  = 4'd1,
        S_LD0H  = 4'd2,
        S_FETCH = 4'd3,
        S_WAIT  = 4'd4,
        S_LD1L  = 4'd5,
        S_LD1H  = 4'd6,
        S_HAM   = 4'd7,
        S_CMP   = 4'd8,
        S_DONE  = 4'd9
    } state_t;

endpackage

// File: rtl/census_wta_seq.sv
// Census/Hamming winner-take-all sequencer: loads the left codec once, then for
// each disparity fetches the right codec, drives the datapath load/Hamming ops
// and keeps the running minimum cost and its disparity.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for iStart; latches left codec and base address
// LD0L  | op 8: left codec bits [63:0]
// LD0H  | op 9: left codec bits [119:64]
// FETCH | one-cycle read request for the right codec at base+d
// WAIT  | hold until iRdValid, capture the right codec
// LD1L  | op A: right codec bits [63:0]
// LD1H  | op B: right codec bits [119:64]
// HAM   | op C: datapath computes the Hamming count
// CMP   | compare registered cost with min, advance d or finish
// DONE  | one-cycle oValid with the winning disparity and cost
module census_wta_seq
    import census_wta_seq_pkg::*;
#(
    parameter int DMAX = 64,
    parameter int AW   = 16
) (
    input  logic               iClk,
    input  logic               iReset,
    input  logic               iStart,
    input  logic [119:0]       iLeft,
    input  logic [AW-1:0]      iBase,
    output logic               oBusy,
    output logic               oValid,
    output logic [7:0]         oDisp,
    output logic [7:0]         oCost,
    output logic               oRdEn,
    output logic [AW-1:0]      oRdAddr,
    input  logic               iRdValid,
    input  logic [119:0]       iRdData,
    output logic               oCeClkEn,
    output logic               oCeStart,
    output logic [3:0]         oCeOp,
    output logic [31:0]        oCeA,
    output logic [31:0]        oCeB,
    input  logic [31:0]        iCeRes
);

    localparam logic [COST_W-1:0] D_LAST = COST_W'(DMAX - 1);

    state_t              state;
    logic [55:0]         leftHi;
    logic [55:0]         rightHi;
    logic [AW-1:0]       base;
    logic [COST_W-1:0]   d;
    logic [COST_W-1:0]   minCost;
    logic [COST_W-1:0]   best;

    logic [COST_W-1:0]   cost;
    logic                better;
    logic                unusedCeRes;

    // Only the low byte of the datapath result carries the Hamming count.
    assign cost        = iCeRes[COST_W-1:0];
    assign better      = cost < minCost;
    assign unusedCeRes = ^iCeRes[31:COST_W];

    // Sequencer FSM; every output is registered on entry to the state it belongs to.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state    <= S_IDLE;
            leftHi   <= '0;
            rightHi  <= '0;
            base     <= '0;
            d        <= '0;
            minCost  <= 8'hFF;
            best     <= '0;
            oBusy    <= 1'b0;
            oValid   <= 1'b0;
            oDisp    <= '0;
            oCost    <= '0;
            oRdEn    <= 1'b0;
            oRdAddr  <= '0;
            oCeClkEn <= 1'b0;
            oCeStart <= 1'b0;
            oCeOp    <= '0;
            oCeA     <= '0;
            oCeB     <= '0;
        end else begin
            oValid   <= 1'b0;
            oRdEn    <= 1'b0;
            oCeClkEn <= 1'b0;
            oCeStart <= 1'b0;
            oCeOp    <= '0;
            oCeA     <= '0;
            oCeB     <= '0;

            case (state)
                S_IDLE: begin
                    if (iStart) begin
                        leftHi   <= iLeft[119:64];
                        base     <= iBase;
                        d        <= '0;
                        minCost  <= 8'hFF;
                        oBusy    <= 1'b1;
                        oCeClkEn <= 1'b1;
                        oCeStart <= 1'b1;
                        oCeOp    <= CE_OP_LD0L;
                        oCeA     <= iLeft[31:0];
                        oCeB     <= iLeft[63:32];
                        state    <= S_LD0L;
                    end
                end
                S_LD0L: begin
                    oCeClkEn <= 1'b1;
                    oCeStart <= 1'b1;
                    oCeOp    <= CE_OP_LD0H;
                    oCeA     <= leftHi[31:0];
                    oCeB     <= {8'd0, leftHi[55:32]};
                    state    <= S_LD0H;
                end
                S_LD0H: begin
                    oRdEn    <= 1'b1;
                    oRdAddr  <= base + AW'(d);
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (iRdValid) begin
                        rightHi  <= iRdData[119:64];
                        oCeClkEn <= 1'b1;
                        oCeStart <= 1'b1;
                        oCeOp    <= CE_OP_LD1L;
                        oCeA     <= iRdData[31:0];
                        oCeB     <= iRdData[63:32];
                        state    <= S_LD1L;
                    end
                end
                S_LD1L: begin
                    oCeClkEn <= 1'b1;
                    oCeStart <= 1'b1;
                    oCeOp    <= CE_OP_LD1H;
                    oCeA     <= rightHi[31:0];
                    oCeB     <= {8'd0, rightHi[55:32]};
                    state    <= S_LD1H;
                end
                S_LD1H: begin
                    oCeClkEn <= 1'b1;
                    oCeStart <= 1'b1;
                    oCeOp    <= CE_OP_HAM;
                    state    <= S_HAM;
                end
                S_HAM: begin
                    state    <= S_CMP;
                end
                S_CMP: begin
                    // Strict less-than keeps the lowest disparity on ties.
                    if (better) begin
                        minCost <= cost;
                        best    <= d;
                    end
                    if (d == D_LAST) begin
                        oValid <= 1'b1;
                        oBusy  <= 1'b0;
                        oDisp  <= better ? d    : best;
                        oCost  <= better ? cost : minCost;
                        state  <= S_DONE;
                    end else begin
                        d       <= d + 8'd1;
                        oRdEn   <= 1'b1;
                        oRdAddr <= base + AW'(d + 8'd1);
                        state   <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/census_wta_seq.md
Name: census_wta_seq

Overview:
- Sequencer for the census/Hamming custom-instruction datapath in the stereo pipeline.
- For one left pixel it loads the 120-bit left census codec once. It then walks DMAX disparity candidates, fetching each right codec from a codec buffer and issuing load and Hamming ops to the datapath.
- Keeps a running winner-take-all minimum and reports the best disparity and its cost.
- Sits between the pixel-level control (or Nios II glue) and the census datapath; it replaces software-issued op sequences.

Parameters:
- DMAX, 64, number of disparity candidates (2..256).
- AW, 16, codec buffer address width.

Ports:
- iClk  in  1  clock.
- iReset  in  1  asynchronous active-low reset.
- iStart  in  1  start request; sampled only in IDLE.
- iLeft  in  120  left census codec, sampled on the accepted iStart.
- iBase  in  AW  buffer address of the disparity-0 right codec, sampled on the accepted iStart.
- oBusy  out  1  high from the cycle after an accepted start until oValid.
- oValid  out  1  one-cycle result strobe.
- oDisp  out  8  winning disparity.
- oCost  out  8  winning Hamming cost (0..120).
- oRdEn  out  1  codec buffer read request, one-cycle pulse.
- oRdAddr  out  AW  codec buffer read address.
- iRdValid  in  1  read data valid; arbitrary latency of 1 cycle or more.
- iRdData  in  120  read codec.
- oCeClkEn  out  1  datapath clock enable.
- oCeStart  out  1  datapath start.
- oCeOp  out  4  datapath op code.
- oCeA  out  32  datapath operand A.
- oCeB  out  32  datapath operand B.
- iCeRes  in  32  datapath registered result.

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, the disparity counter is 0 and the min register is 8'hFF. Reset mid-operation abandons the run with no oValid. The datapath is not cleared.
- Op issue: oCeClkEn=oCeStart=1 for exactly one cycle per op, with oCeOp/oCeA/oCeB valid in that cycle. Both are 0 in all other cycles.
- Op codes:
  - 8 loads codec0[63:0]={B,A}.
  - 9 loads codec0[119:64]={B[23:0],A}.
  - A loads codec1[63:0].
  - B loads codec1[119:64].
  - C makes the result the Hamming count in [7:0].
- The datapath result is registered, so iCeRes is sampled exactly one cycle after the C issue. The datapath done flag is not used.
- States:
  - IDLE: on iStart latch iLeft, iBase, d=0, min=FF; go to LD0L.
  - LD0L: issue 8, A=left[31:0], B=left[63:32].
  - LD0H: issue 9, A=left[95:64], B={8'd0,left[119:96]}.
  - FETCH: oRdEn=1, oRdAddr=iBase+d, truncated to AW bits (wraps modulo 2^AW).
  - WAIT: hold until iRdValid, then latch iRdData. oRdEn stays 0.
  - LD1L: issue A with the right codec words 0,1.
  - LD1H: issue B with words 2 and {8'd0,[119:96]}.
  - HAM: issue C.
  - CMP: cost=iCeRes[7:0]. If cost<min, set min=cost and best=d. Strict less-than, so the lowest d wins ties. If d==DMAX-1 go to DONE, else d=d+1 and go to FETCH.
  - DONE: oValid=1, oDisp=best, oCost=min; go to IDLE.
- oDisp/oCost hold until the next oValid.
- oBusy=0 in IDLE and in the DONE cycle.
- iStart while busy is ignored. iStart in the DONE cycle is ignored, because it is not sampled in IDLE.
- iRdValid outside WAIT is ignored.
- The d counter is 8 bits, so DMAX=256 terminates on d==255 without overflow.
- Latency with 1-cycle read latency: 3 + 6*DMAX cycles from the accepted iStart to oValid. Each extra read-latency cycle adds 1 per disparity.

Decomposition:
- Shared package holds:
  - op code constants CE_OP_LD0L=4'h8, CE_OP_LD0H=4'h9, CE_OP_LD1L=4'hA, CE_OP_LD1H=4'hB, CE_OP_HAM=4'hC;
  - the FSM state encoding;
  - CODEC_W=120 and COST_W=8.
- Single module. No sub-module is warranted; the WTA compare is inline.

Test Plan:
- Single-hot minimum: DMAX=4, left=0, buffer codecs have popcounts 10,3,7,3 at base..base+3 -> oDisp=1, oCost=3 (tie goes to the lower d). oValid exactly one cycle, 3+24=27 cycles after start.
- Exact match: buffer word at d=2 equals iLeft, others are ~iLeft -> oDisp=2, oCost=0. Cost is 120 at the other disparities.
- Op trace: check the issue order 8,9 then (A,B,C)*DMAX. Check operand packing: upper words carry zero-extended [119:96]. oCeStart is single-cycle, with a gap to the next op.
- Address wrap: AW=4, iBase=14, DMAX=4 -> read addresses 14,15,0,1.
- Stalls and ignored start: iRdValid delayed 3 cycles at each read -> same result, latency 3+9*DMAX. A second iStart mid-run has no effect.
- Reset mid-run: assert iReset during LD1H of d=5 -> all outputs 0 and no oValid. A new start then completes normally.
